alu64_twopass_ctrl: RTL

//   Sequencer that executes a 64-bit Y86-64 OPq operation (add, sub, and, xor) on a

---
 rtl/alu64_twopass_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu64_twopass_ctrl.sv
// Two-pass 64-bit OPq sequencer that uses a single shared 32-bit ALU slice.
// The low half runs first, its carry/borrow feeds the high half, and the flags come from the full result.
module alu64_twopass_ctrl #(
  parameter int HALF_W = 32,
  parameter int W      = 2 * HALF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   ifun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          ifun_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [HALF_W-1:0]   lo_q;
  logic                carry_q;
  logic                accept;
  logic                is_sub;
  logic [HALF_W-1:0]   alu_a;
  logic [HALF_W-1:0]   alu_b;
  logic [HALF_W-1:0]   alu_y;
  logic                alu_cin;
  logic [HALF_W:0]     sum;
  logic [W-1:0]        full_r;
  logic                of_nxt;

  // Gating with rst_n keeps in_ready low for as long as reset is held.
  assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign is_sub    = (ifun_q == 2'd1);

  // Shared slice: subtraction is implemented as a + ~b + 1, with the +1 entering on the low pass.
  always_comb begin
    alu_a   = (state == HI) ? a_q[W-1:HALF_W] : a_q[HALF_W-1:0];
    alu_b   = (state == HI) ? b_q[W-1:HALF_W] : b_q[HALF_W-1:0];
    alu_cin = (state == HI) ? carry_q : is_sub;
    sum     = {1'b0, alu_a} + {1'b0, (is_sub ? ~alu_b : alu_b)} + {{HALF_W{1'b0}}, alu_cin};
    case (ifun_q)
      2'd0, 2'd1: alu_y = sum[HALF_W-1:0];
      2'd2:       alu_y = alu_a & alu_b;
      default:    alu_y = alu_a ^ alu_b;
    endcase
    full_r = {alu_y, lo_q};
    case (ifun_q)
      2'd0:    of_nxt = (a_q[W-1] == b_q[W-1]) & (alu_y[HALF_W-1] != a_q[W-1]);
      2'd1:    of_nxt = (a_q[W-1] != b_q[W-1]) & (alu_y[HALF_W-1] != a_q[W-1]);
      default: of_nxt = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LO;
      LO:   state_nxt = HI;
      HI:   state_nxt = DONE;
      DONE: if (out_ready) state_nxt = accept ? LO : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operands are captured only on accept, so changes to the inputs during an operation are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifun_q <= 2'd0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (accept) begin
      ifun_q <= ifun;
      a_q    <= a;
      b_q    <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q    <= '0;
      carry_q <= 1'b0;
    end else if (state == LO) begin
      lo_q    <= alu_y;
      carry_q <= sum[HALF_W];
    end
  end

  // The visible result is written only on the high pass, so it stays stable through a back-to-back low pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      cc_zf  <= 1'b0;
      cc_sf  <= 1'b0;
      cc_of  <= 1'b0;
    end else if (state == HI) begin
      result <= full_r;
      cc_zf  <= (full_r == '0);
      cc_sf  <= alu_y[HALF_W-1];
      cc_of  <= of_nxt;
    end
  end

endmodule
